// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the MIPS datapath: steps each instruction
// through its states, drives datapath controls, handshakes with memory, counts retires.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_wr,
  output logic [3:0]  state,
  output logic        retire,
  output logic [31:0] retire_cnt,
  output logic        illegal_op,
  output logic        err
);

  // state   | meaning
  // FETCH   | read instruction at PC, PC <= PC+4 on ack (idle while run=0)
  // DECODE  | dispatch on opcode, precompute branch target
  // MEMADR  | ALU computes rs + imm for lw/sw
  // MEMRD   | data read, wait for ack
  // MEMWB   | load data written to rt
  // MEMWR   | data write, wait for ack
  // EXEC    | R-type ALU operation
  // RWB     | R-type result written to rd
  // BRANCH  | beq/bne compare, conditional PC load
  // JUMP    | PC <= jump address
  // ADDI_EX | ALU computes rs + imm
  // ADDI_WB | addi result written to rt
  // HALT    | memory watchdog expired, wait for reset
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t          state_q, state_d;
  logic [TO_W-1:0] wcnt_q;
  logic            waiting;
  logic            timeout;

  // Memory wait states; the counter is cleared everywhere else, so entry sees zero.
  assign waiting = ((state_q == FETCH) && run) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout = waiting && !mem_ack && (TIMEOUT != 0) && (wcnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      wcnt_q     <= '0;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (waiting && !mem_ack) wcnt_q <= wcnt_q + 1'b1;
      else                     wcnt_q <= '0;
      if (retire) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    err        = 1'b0;
    // Outputs are held low for the whole reset, not just until the state register settles.
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          if (run) begin
            mem_rd    = 1'b1;
            alu_src_b = 2'b01;
            ir_wr     = mem_ack;
            pc_wr     = mem_ack;
            if (mem_ack)      state_d = DECODE;
            else if (timeout) state_d = HALT;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          unique case (opcode)
            OP_RTYPE:      state_d = EXEC;
            OP_LW, OP_SW:  state_d = MEMADR;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_J:          state_d = JUMP;
            OP_ADDI:       state_d = ADDI_EX;
            default: begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
          if (mem_ack)      state_d = MEMWB;
          else if (timeout) state_d = HALT;
        end
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_wr     = 1'b1;
          retire     = 1'b1;
          state_d    = FETCH;
        end
        MEMWR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
          retire = mem_ack;
          if (mem_ack)      state_d = FETCH;
          else if (timeout) state_d = HALT;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = RWB;
        end
        RWB: begin
          reg_dst = 1'b1;
          reg_wr  = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          retire    = 1'b1;
          // opcode[0] separates bne from beq
          pc_wr     = opcode[0] ? ~alu_zero : alu_zero;
          state_d   = FETCH;
        end
        JUMP: begin
          pc_src  = 2'b10;
          pc_wr   = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
        ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = ADDI_WB;
        end
        ADDI_WB: begin
          reg_wr  = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
        HALT: begin
          err     = 1'b1;
          state_d = HALT;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: instruction sequences, memory waits,
// illegal opcode, reset abort and watchdog halt, each against hand-derived values.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        mem_ack;
  logic        mem_rd, mem_wr, iord, ir_wr, pc_wr;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_wr;
  logic [3:0]  state;
  logic        retire;
  logic [31:0] retire_cnt;
  logic        illegal_op, err;

  int n_chk = 0;
  int n_err = 0;

  mc_ctrl_fsm #(.TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
    .state(state), .retire(retire), .retire_cnt(retire_cnt), .illegal_op(illegal_op),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  // Zero-wait instruction: sts holds the expected state per cycle, nibble 0 first.
  task automatic do_instr(input string tag, input logic [5:0] op, input logic az,
                          input int n, input logic [19:0] sts, input logic pcwr_last);
    opcode   = op;
    alu_zero = az;
    mem_ack  = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_state"}, 32'(state), 32'(sts[4*i +: 4]));
      chk({tag, "_retire"}, 32'(retire), (i == n - 1) ? 32'd1 : 32'd0);
      if (i == 0) chk({tag, "_irwr"}, 32'(ir_wr), 32'd1);
      if (i == n - 1) chk({tag, "_pcwr"}, 32'(pc_wr), 32'(pcwr_last));
      next_cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; opcode = 6'd0; alu_zero = 1'b0; mem_ack = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_memrd", 32'(mem_rd), 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    next_cyc();
    rst_n = 1'b1;

    do_instr("lw",  6'b100011, 1'b0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);
    do_instr("sw",  6'b101011, 1'b0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b0);
    do_instr("add", 6'b000000, 1'b0, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b0);
    do_instr("beq", 6'b000100, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b1);
    do_instr("j",   6'b000010, 1'b0, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 1'b1);
    #1 chk("cnt_after5", retire_cnt, 32'd5);

    do_instr("bne_z1", 6'b000101, 1'b1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b0);
    opcode = 6'b000101; alu_zero = 1'b0; mem_ack = 1'b1;
    #1 chk("bne_z0_fetch", 32'(state), 32'd0);
    next_cyc();
    #1 chk("bne_z0_dec", 32'(state), 32'd1);
    next_cyc();
    #1;
    chk("bne_z0_state", 32'(state), 32'd8);
    chk("bne_z0_pcwr", 32'(pc_wr), 32'd1);
    chk("bne_z0_pcsrc", 32'(pc_src), 32'd1);
    next_cyc();
    do_instr("addi", 6'b001000, 1'b0, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 1'b0);
    #1 chk("cnt_after8", retire_cnt, 32'd8);

    // lw with three wait cycles in MEMRD: 8 cycles total
    opcode = 6'b100011; mem_ack = 1'b1;
    #1 chk("lwd_fetch", 32'(state), 32'd0);
    next_cyc();
    #1 chk("lwd_dec", 32'(state), 32'd1);
    next_cyc();
    #1 chk("lwd_adr", 32'(state), 32'd2);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      chk("lwd_rd_state", 32'(state), 32'd3);
      chk("lwd_memrd", 32'(mem_rd), 32'd1);
      chk("lwd_iord", 32'(iord), 32'd1);
      next_cyc();
    end
    #1;
    chk("lwd_wb", 32'(state), 32'd4);
    chk("lwd_wb_retire", 32'(retire), 32'd1);
    next_cyc();
    #1 chk("cnt_after9", retire_cnt, 32'd9);

    // illegal opcode
    opcode = 6'b111111; mem_ack = 1'b1;
    #1 chk("ill_fetch_pulse", 32'(illegal_op), 32'd0);
    next_cyc();
    #1;
    chk("ill_dec", 32'(state), 32'd1);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    next_cyc();
    #1;
    chk("ill_back", 32'(state), 32'd0);
    chk("ill_pulse_gone", 32'(illegal_op), 32'd0);
    chk("ill_cnt", retire_cnt, 32'd9);

    // reset during an unacknowledged write
    next_cyc();
    opcode = 6'b101011; mem_ack = 1'b1;
    next_cyc();
    next_cyc();
    mem_ack = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd5);
    chk("abort_memwr", 32'(mem_wr), 32'd1);
    chk("abort_noretire", 32'(retire), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rst_state", 32'(state), 32'd0);
    chk("abort_rst_memwr", 32'(mem_wr), 32'd0);
    chk("abort_rst_cnt", retire_cnt, 32'd0);
    run = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_memrd", 32'(mem_rd), 32'd0);
      next_cyc();
    end

    // watchdog: no ack in FETCH, HALT after 16 request cycles
    run = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("wd_state", 32'(state), 32'd0);
      chk("wd_memrd", 32'(mem_rd), 32'd1);
      next_cyc();
    end
    #1;
    chk("halt_state", 32'(state), 32'd12);
    chk("halt_err", 32'(err), 32'd1);
    chk("halt_memrd", 32'(mem_rd), 32'd0);
    mem_ack = 1'b1;
    next_cyc();
    #1 chk("halt_hold", 32'(state), 32'd12);
    #1 rst_n = 1'b0;
    #1;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
